// File: rtl/arbiter_mux_pkg.sv
// Shared types for the arbiter_mux slice: the held request record and the
// idle-grant encoding. The request struct widths are fixed here; the
// arbiter_mux ADDR_WIDTH/DATA_WIDTH parameters default to these values.
package arbiter_mux_pkg;

    localparam int unsigned PKG_ADDR_WIDTH = 20;
    localparam int unsigned PKG_DATA_WIDTH = 16;

    // One manager request as captured by the holding register.
    typedef struct packed {
        logic                      we;
        logic [PKG_ADDR_WIDTH-1:0] addr;
        logic [PKG_DATA_WIDTH-1:0] wdata;
    } req_t;

    // A grant index equal to the manager count means "no grant".
    function automatic int unsigned idle_grant(input int unsigned num_m);
        return num_m;
    endfunction

endpackage

// File: rtl/req_hold_reg.sv
// 1-entry valid/ready holding register. Ready is low while an entry is held,
// so a capture and a release can never target the same cycle.
module req_hold_reg
    import arbiter_mux_pkg::*;
(
    input  logic clk,
    input  logic rst,
    input  logic i_valid,
    output logic o_ready,
    input  req_t i_req,
    input  logic i_clear,
    output logic o_held,
    output req_t o_req
);

    logic r_held;
    req_t r_req;

    // Capture on the valid/ready handshake, release when downstream accepts.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_held <= 1'b0;
            r_req  <= '0;
        end else if (i_valid && !r_held) begin
            r_held <= 1'b1;
            r_req  <= i_req;
        end else if (i_clear) begin
            r_held <= 1'b0;
        end
    end

    assign o_ready = !r_held;
    assign o_held  = r_held;
    assign o_req   = r_req;

endmodule

// File: rtl/arbiter_mux.sv
// Datapath stage behind the grant arbiter: holds one request per manager,
// forwards the request picked by g_req to the subordinate and steers the
// in-order responses back to the manager named by g_resp.
// Handshake: a request transfers on any edge where valid && ready are both
// high; the response channel has no backpressure (s_rvalid is always taken).
// Optional build macro ARBITER_MUX_RESP_REG_EN registers m_rvalid/m_rdata
// (one cycle after s_rvalid); without it they pass straight through.
module arbiter_mux
    import arbiter_mux_pkg::*;
#(
    parameter  int NUM_M      = 2,
    parameter  int ADDR_WIDTH = PKG_ADDR_WIDTH,
    parameter  int DATA_WIDTH = PKG_DATA_WIDTH,
    localparam int G_BITS     = $clog2(NUM_M + 1)
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic [NUM_M-1:0]             m_valid,
    output logic [NUM_M-1:0]             m_ready,
    input  logic [NUM_M-1:0]             m_we,
    input  logic [NUM_M*ADDR_WIDTH-1:0]  m_addr,
    input  logic [NUM_M*DATA_WIDTH-1:0]  m_wdata,
    output logic [NUM_M-1:0]             m_rvalid,
    output logic [DATA_WIDTH-1:0]        m_rdata,
    output logic [NUM_M-1:0]             g_want,
    input  logic [G_BITS-1:0]            g_req,
    input  logic [G_BITS-1:0]            g_resp,
    output logic                         req_accepted,
    output logic                         resp_accepted,
    output logic                         s_valid,
    input  logic                         s_ready,
    output logic                         s_we,
    output logic [ADDR_WIDTH-1:0]        s_addr,
    output logic [DATA_WIDTH-1:0]        s_wdata,
    input  logic                         s_rvalid,
    input  logic [DATA_WIDTH-1:0]        s_rdata
);

    localparam logic [G_BITS-1:0] IDLE = G_BITS'(idle_grant(NUM_M));

    logic [NUM_M-1:0] w_held;
    logic [NUM_M-1:0] w_clear;
    logic [NUM_M-1:0] w_resp_onehot;
    req_t             w_in_req [NUM_M];
    req_t             w_hold   [NUM_M];
    req_t             w_sel;
    logic             w_sel_held;

    for (genvar gi = 0; gi < NUM_M; gi++) begin : g_hold
        assign w_in_req[gi] = '{
            we:    m_we[gi],
            addr:  m_addr[gi*ADDR_WIDTH +: ADDR_WIDTH],
            wdata: m_wdata[gi*DATA_WIDTH +: DATA_WIDTH]
        };
        assign w_clear[gi] = req_accepted && (g_req == G_BITS'(gi));

        req_hold_reg u_hold (
            .clk     (clk),
            .rst     (rst),
            .i_valid (m_valid[gi]),
            .o_ready (m_ready[gi]),
            .i_req   (w_in_req[gi]),
            .i_clear (w_clear[gi]),
            .o_held  (w_held[gi]),
            .o_req   (w_hold[gi])
        );
    end

    assign g_want = w_held;

    // Select the granted holding register; out-of-range grants read as idle.
    always_comb begin
        w_sel      = '0;
        w_sel_held = 1'b0;
        for (int i = 0; i < NUM_M; i++) begin
            if (g_req == G_BITS'(i)) begin
                w_sel      = w_hold[i];
                w_sel_held = w_held[i];
            end
        end
    end

    assign s_valid       = (g_req != IDLE) && w_sel_held;
    assign s_we          = w_sel.we;
    assign s_addr        = w_sel.addr;
    assign s_wdata       = w_sel.wdata;
    assign req_accepted  = s_valid && s_ready;
    assign resp_accepted = s_rvalid;

    // Decode which manager owns this cycle's response; idle grant drops it.
    always_comb begin
        w_resp_onehot = '0;
        for (int i = 0; i < NUM_M; i++) begin
            if (s_rvalid && (g_resp == G_BITS'(i))) begin
                w_resp_onehot[i] = 1'b1;
            end
        end
    end

`ifdef ARBITER_MUX_RESP_REG_EN
    logic [NUM_M-1:0]      r_rvalid;
    logic [DATA_WIDTH-1:0] r_rdata;

    // Register the steered response; data holds until the next delivery.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_rvalid <= '0;
            r_rdata  <= '0;
        end else begin
            r_rvalid <= w_resp_onehot;
            if (|w_resp_onehot) begin
                r_rdata <= s_rdata;
            end
        end
    end

    assign m_rvalid = r_rvalid;
    assign m_rdata  = r_rdata;
`else
    assign m_rvalid = w_resp_onehot;
    assign m_rdata  = s_rdata;
`endif

endmodule
